// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU control sequencer.
// Contents:
//   opcode_e      - 4-bit instruction opcodes (upper nibble of IR)
//   ctrl_word_t   - one bit per control strobe, plus an internal halt request
//   FETCH0_CW     - strobes for microstep 0 (PC -> MAR)
//   FETCH1_CW     - strobes for microstep 1 (RAM -> IR, PC++)
package cpu_ctrl_pkg;

  localparam int STEP_W = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Bus strobe protocol: a *_write strobe means the module drives the bus,
  // a *_read strobe means it captures the bus. Strobes are held for the whole
  // cycle and acted on by the target at the next rising edge; there is no
  // back-pressure, so a target must always accept in the cycle it is strobed.
  typedef struct packed {
    logic mar_read;
    logic ram_read;
    logic ram_write;
    logic ir_read;
    logic ir_write;
    logic a_read;
    logic a_write;
    logic b_read;
    logic alu_write;
    logic alu_sub;
    logic flags_load;
    logic out_read;
    logic pc_inc;
    logic pc_write;
    logic pc_load;
    logic halt_req;   // not a port; tells the sequencer to stop
  } ctrl_word_t;

  localparam ctrl_word_t FETCH0_CW = '{mar_read: 1'b1, pc_write: 1'b1, default: 1'b0};
  localparam ctrl_word_t FETCH1_CW = '{ram_write: 1'b1, ir_read: 1'b1, pc_inc: 1'b1,
                                       default: 1'b0};

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table.
// Ports:
//   i_opcode - opcode from IR[7:4]
//   i_step   - current microstep
//   i_carry  - registered carry flag (only looked at in step 2)
//   i_zero   - registered zero flag (only looked at in step 2)
//   o_cw     - control word for this step
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [STEP_W-1:0]   i_step,
  input  logic                i_carry,
  input  logic                i_zero,
  output ctrl_word_t          o_cw
);

  opcode_e w_op;
  assign w_op = opcode_e'(i_opcode[3:0]);

  always_comb begin
    o_cw = '0;
    case (i_step)
      // Fetch ignores the opcode: IR still holds the previous instruction here.
      3'd0: o_cw = FETCH0_CW;
      3'd1: o_cw = FETCH1_CW;
      3'd2: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_cw.ir_write = 1'b1;
            o_cw.mar_read = 1'b1;
          end
          OP_LDI: begin
            o_cw.ir_write = 1'b1;
            o_cw.a_read   = 1'b1;
          end
          OP_JMP: begin
            o_cw.ir_write = 1'b1;
            o_cw.pc_load  = 1'b1;
          end
          OP_JC: begin
            o_cw.ir_write = i_carry;
            o_cw.pc_load  = i_carry;
          end
          OP_JZ: begin
            o_cw.ir_write = i_zero;
            o_cw.pc_load  = i_zero;
          end
          OP_OUT: begin
            o_cw.a_write  = 1'b1;
            o_cw.out_read = 1'b1;
          end
          OP_HLT:  o_cw.halt_req = 1'b1;
          default: o_cw = '0;
        endcase
      end
      3'd3: begin
        case (w_op)
          OP_LDA: begin
            o_cw.ram_write = 1'b1;
            o_cw.a_read    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_cw.ram_write = 1'b1;
            o_cw.b_read    = 1'b1;
          end
          OP_STA: begin
            o_cw.a_write  = 1'b1;
            o_cw.ram_read = 1'b1;
          end
          default: o_cw = '0;
        endcase
      end
      3'd4: begin
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          o_cw.alu_write  = 1'b1;
          o_cw.a_read     = 1'b1;
          o_cw.flags_load = 1'b1;
          o_cw.alu_sub    = (w_op == OP_SUB);
        end
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: step counter, halt register and strobe outputs.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   opcode              - IR[7:4]
//   carry_flag/zero_flag- registered ALU flags
//   step, halted        - sequencer state (also serves as debug view)
//   remaining outputs   - bus / PC / ALU control strobes, combinational
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter int OPCODE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic [2:0]          step,
  output logic                halted,
  output logic                mar_read,
  output logic                ram_read,
  output logic                ram_write,
  output logic                ir_read,
  output logic                ir_write,
  output logic                a_read,
  output logic                a_write,
  output logic                b_read,
  output logic                alu_write,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_read,
  output logic                pc_inc,
  output logic                pc_write,
  output logic                pc_load
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] HALT_STEP = 3'd3;

  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  ctrl_word_t        w_cw_raw;
  ctrl_word_t        w_cw;

  microcode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .i_opcode (opcode),
    .i_step   (r_step),
    .i_carry  (carry_flag),
    .i_zero   (zero_flag),
    .o_cw     (w_cw_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (w_cw_raw.halt_req) begin
        // Park at step 3 explicitly so the frozen value does not depend on NUM_STEPS.
        r_halted <= 1'b1;
        r_step   <= HALT_STEP;
      end else if (r_step == LAST_STEP) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + 3'd1;
      end
    end
  end

  assign w_cw = r_halted ? ctrl_word_t'('0) : w_cw_raw;

  assign step       = r_step;
  assign halted     = r_halted;
  assign mar_read   = w_cw.mar_read;
  assign ram_read   = w_cw.ram_read;
  assign ram_write  = w_cw.ram_write;
  assign ir_read    = w_cw.ir_read;
  assign ir_write   = w_cw.ir_write;
  assign a_read     = w_cw.a_read;
  assign a_write    = w_cw.a_write;
  assign b_read     = w_cw.b_read;
  assign alu_write  = w_cw.alu_write;
  assign alu_sub    = w_cw.alu_sub;
  assign flags_load = w_cw.flags_load;
  assign out_read   = w_cw.out_read;
  assign pc_inc     = w_cw.pc_inc;
  assign pc_write   = w_cw.pc_write;
  assign pc_load    = w_cw.pc_load;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int W = 19;  // {step[2:0], halted, 15 strobes}

  // strobe bit positions in the packed observation vector
  localparam int MAR = 14, RAMR = 13, RAMW = 12, IRR = 11, IRW = 10, AR = 9, AW = 8;
  localparam int BR = 7, ALUW = 6, SUBB = 5, FL = 4, OUTR = 3, PCI = 2, PCW = 1, PCL = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic [2:0] step;
  logic       halted;
  logic mar_read, ram_read, ram_write, ir_read, ir_write, a_read, a_write, b_read;
  logic alu_write, alu_sub, flags_load, out_read, pc_inc, pc_write, pc_load;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // reference state
  logic [2:0] m_step = 3'd0;
  logic       m_halt = 1'b0;

  control_sequencer #(.NUM_STEPS(5), .OPCODE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step(step), .halted(halted), .mar_read(mar_read), .ram_read(ram_read),
    .ram_write(ram_write), .ir_read(ir_read), .ir_write(ir_write), .a_read(a_read),
    .a_write(a_write), .b_read(b_read), .alu_write(alu_write), .alu_sub(alu_sub),
    .flags_load(flags_load), .out_read(out_read), .pc_inc(pc_inc), .pc_write(pc_write),
    .pc_load(pc_load)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_strobes(input logic [2:0] s, input logic h,
                                              input logic [3:0] op, input logic c,
                                              input logic z);
    logic [14:0] v;
    v = '0;
    if (!h) begin
      case (s)
        3'd0: begin v[PCW] = 1'b1; v[MAR] = 1'b1; end
        3'd1: begin v[RAMW] = 1'b1; v[IRR] = 1'b1; v[PCI] = 1'b1; end
        3'd2: begin
          case (op)
            4'h1, 4'h2, 4'h3, 4'h4: begin v[IRW] = 1'b1; v[MAR] = 1'b1; end
            4'h5: begin v[IRW] = 1'b1; v[AR] = 1'b1; end
            4'h6: begin v[IRW] = 1'b1; v[PCL] = 1'b1; end
            4'h7: if (c) begin v[IRW] = 1'b1; v[PCL] = 1'b1; end
            4'h8: if (z) begin v[IRW] = 1'b1; v[PCL] = 1'b1; end
            4'hE: begin v[AW] = 1'b1; v[OUTR] = 1'b1; end
            default: v = '0;
          endcase
        end
        3'd3: begin
          case (op)
            4'h1: begin v[RAMW] = 1'b1; v[AR] = 1'b1; end
            4'h2, 4'h3: begin v[RAMW] = 1'b1; v[BR] = 1'b1; end
            4'h4: begin v[AW] = 1'b1; v[RAMR] = 1'b1; end
            default: v = '0;
          endcase
        end
        3'd4: begin
          if (op == 4'h2 || op == 4'h3) begin
            v[ALUW] = 1'b1; v[AR] = 1'b1; v[FL] = 1'b1;
            v[SUBB] = (op == 4'h3);
          end
        end
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [W-1:0] observe();
    return {step, halted, mar_read, ram_read, ram_write, ir_read, ir_write, a_read, a_write,
            b_read, alu_write, alu_sub, flags_load, out_read, pc_inc, pc_write, pc_load};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs for one cycle, push the expected post-edge view,
  // then pop and compare after the edge.
  task automatic cyc(input logic r, input logic [3:0] op, input logic c, input logic z);
    logic [W-1:0] e;
    rst = r; opcode = op; carry_flag = c; zero_flag = z;
    if (r) begin
      m_step = 3'd0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 3'd2 && op == 4'hF) begin
        m_step = 3'd3; m_halt = 1'b1;
      end else begin
        m_step = (m_step == 3'd4) ? 3'd0 : m_step + 3'd1;
      end
    end
    exp_q.push_back({m_step, m_halt, exp_strobes(m_step, m_halt, op, c, z)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", observe(), e);
    check("bus_one_hot", W'($countones({ram_write, ir_write, a_write, alu_write, pc_write}) <= 1),
          W'(1));
  endtask

  task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
    for (int i = 0; i < 5; i++) cyc(1'b0, op, c, z);
  endtask

  initial begin
    // reset then fetch with NOP
    cyc(1'b1, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0);
    check("reset_view", observe(), {3'd0, 1'b0, 15'b100000000000010});
    run_instr(4'h0, 1'b0, 1'b0);

    // ADD, with a direct look at step 4
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h2, 1'b0, 1'b0);
    check("add_s4", W'({step, alu_write, a_read, flags_load, alu_sub}), W'({3'd4, 4'b1110}));
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    // SUB
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h3, 1'b0, 1'b0);
    check("sub_s4", W'({step, alu_write, a_read, flags_load, alu_sub}), W'({3'd4, 4'b1111}));
    cyc(1'b0, 4'h3, 1'b0, 1'b0);

    // remaining opcodes
    run_instr(4'h1, 1'b0, 1'b0);
    run_instr(4'h4, 1'b0, 1'b0);
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'h6, 1'b0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0);
    run_instr(4'hB, 1'b1, 1'b1);

    // conditional jumps, both flag values
    run_instr(4'h7, 1'b0, 1'b0);
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b1);
    // carry toggled outside step 2 has no effect
    cyc(1'b0, 4'h7, 1'b0, 1'b0);
    cyc(1'b0, 4'h7, 1'b0, 1'b0);
    check("jc_c0_s2", W'({step, ir_write, pc_load}), W'({3'd2, 2'b00}));
    cyc(1'b0, 4'h7, 1'b1, 1'b0);
    cyc(1'b0, 4'h7, 1'b0, 1'b0);
    cyc(1'b0, 4'h7, 1'b1, 1'b0);

    // LDA interrupted by reset during step 3
    cyc(1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    check("rst_mid", W'({step, ram_write, a_read, pc_write, mar_read}), W'({3'd0, 4'b0011}));
    cyc(1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b0, 4'h1, 1'b0, 1'b0);

    // HLT from step 2, then hold
    cyc(1'b0, 4'hF, 1'b0, 1'b0);
    check("hlt_s3", W'({step, halted}), W'({3'd3, 1'b1}));
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("hlt_hold", observe(), {3'd3, 1'b1, 15'b0});
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    check("hlt_clear", W'({step, halted}), W'({3'd0, 1'b0}));

    // random opcodes and flags; reset whenever halted, plus occasional resets
    for (int i = 0; i < 2000; i++) begin
      cyc(m_halt || ($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
